// File: rtl/systolic_array_ws.sv
// Weight-stationary ROWSxCOLS signed MAC array with input skew, output deskew,
// a weight-load FSM and valid/ready handshakes that stall the whole pipeline.
// Optional feature macro: SYSTOLIC_SAT_EN clamps each column result to the signed
// OUT_W range instead of keeping the low OUT_W bits of the partial sum.
module systolic_array_ws #(
    parameter int unsigned ROWS   = 3,
    parameter int unsigned COLS   = 3,
    parameter int unsigned DATA_W = 13,
    parameter int unsigned PSUM_W = 32,
    parameter int unsigned OUT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [COLS*DATA_W-1:0]   w_data,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [ROWS*DATA_W-1:0]   a_data,
    output logic                     y_valid,
    input  logic                     y_ready,
    output logic [COLS*OUT_W-1:0]    y_data,
    output logic                     busy
);

    localparam int unsigned LAT    = ROWS + COLS - 1;
    localparam int unsigned WROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned INF_W  = $clog2(ROWS + COLS + 1);

`ifdef SYSTOLIC_SAT_EN
    localparam logic signed [PSUM_W-1:0] SAT_MAX =
        {{(PSUM_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [PSUM_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {StLoad, StCompute, StDrain} state_e;

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [WROW_W-1:0]        r_wrow;
    logic [INF_W-1:0]         r_inflight;
    logic signed [DATA_W-1:0] r_w [ROWS][COLS];
    logic [LAT-1:0]           r_vld;

    logic                     w_step;
    logic                     w_a_acc;
    logic                     w_y_acc;
    logic                     w_w_acc;
    logic [ROWS*DATA_W-1:0]   w_a_gated;
    logic signed [DATA_W-1:0] w_ain  [ROWS][COLS];
    logic signed [PSUM_W-1:0] w_pin  [ROWS][COLS];
    logic signed [OUT_W-1:0]  w_ybot [COLS];

    // Column psum to output element: clamp or wrap depending on build.
    function automatic logic signed [OUT_W-1:0] to_out(input logic signed [PSUM_W-1:0] p);
`ifdef SYSTOLIC_SAT_EN
        if (p > SAT_MAX) begin
            return OUT_W'(SAT_MAX);
        end else if (p < SAT_MIN) begin
            return OUT_W'(SAT_MIN);
        end
        return OUT_W'(p);
`else
        return OUT_W'(p);
`endif
    endfunction

    assign y_valid   = r_vld[LAT-1];
    assign w_step    = !y_valid || y_ready;
    assign w_a_acc   = a_valid && a_ready;
    assign w_y_acc   = y_valid && y_ready;
    assign w_w_acc   = w_valid && w_ready;
    assign busy      = (r_inflight != '0);
    // Unaccepted steps inject zero bubbles.
    assign w_a_gated = w_a_acc ? a_data : '0;

    // FSM next state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        a_ready     = 1'b0;
        unique case (r_state)
            StLoad: begin
                w_ready = 1'b1;
                if (w_valid && (r_wrow == WROW_W'(ROWS - 1))) begin
                    w_state_nxt = StCompute;
                end
            end
            StCompute: begin
                // A pending weight reload wins over a new activation.
                a_ready = w_step && !w_valid;
                if (w_valid) begin
                    w_state_nxt = StDrain;
                end
            end
            StDrain: begin
                if (r_inflight == '0) begin
                    w_state_nxt = StLoad;
                end
            end
            default: w_state_nxt = StLoad;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Weight row pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrow <= '0;
        end else if (w_w_acc) begin
            r_wrow <= (r_wrow == WROW_W'(ROWS - 1)) ? '0 : r_wrow + 1'b1;
        end
    end

    // Stationary weights, written one row per accepted beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    r_w[r][c] <= '0;
                end
            end
        end else if (w_w_acc) begin
            for (int r = 0; r < ROWS; r++) begin
                if (r_wrow == WROW_W'(r)) begin
                    for (int c = 0; c < COLS; c++) begin
                        r_w[r][c] <= w_data[c*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Vectors accepted but not yet taken downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
        end else if (w_a_acc && !w_y_acc) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (!w_a_acc && w_y_acc) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    generate
        if (LAT == 1) begin : g_vld_one
            // Valid bit travelling alongside the single pipeline stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld <= '0;
                end else if (w_step) begin
                    r_vld <= w_a_acc;
                end
            end
        end else begin : g_vld_chain
            // Valid bit travelling alongside skew, array and deskew.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld <= '0;
                end else if (w_step) begin
                    r_vld <= {r_vld[LAT-2:0], w_a_acc};
                end
            end
        end

        for (genvar r = 0; r < ROWS; r++) begin : g_skew
            if (r == 0) begin : g_direct
                assign w_ain[0][0] = w_a_gated[0 +: DATA_W];
            end else begin : g_delay
                logic signed [DATA_W-1:0] r_sk [r];
                // Row r input delayed r steps.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        for (int k = 0; k < r; k++) begin
                            r_sk[k] <= '0;
                        end
                    end else if (w_step) begin
                        r_sk[0] <= w_a_gated[r*DATA_W +: DATA_W];
                        for (int k = 1; k < r; k++) begin
                            r_sk[k] <= r_sk[k-1];
                        end
                    end
                end
                assign w_ain[r][0] = r_sk[r-1];
            end
        end

        for (genvar c = 0; c < COLS; c++) begin : g_top
            assign w_pin[0][c] = '0;
        end

        for (genvar r = 0; r < ROWS; r++) begin : g_row
            for (genvar c = 0; c < COLS; c++) begin : g_cell
                logic signed [2*DATA_W-1:0] w_prod;
                logic signed [PSUM_W-1:0]   w_sum;

                assign w_prod = w_ain[r][c] * r_w[r][c];
                assign w_sum  = w_pin[r][c] + PSUM_W'(w_prod);

                if (c < COLS - 1) begin : g_aout
                    logic signed [DATA_W-1:0] r_a;
                    // Activation passes right.
                    always_ff @(posedge clk) begin
                        if (reset) begin
                            r_a <= '0;
                        end else if (w_step) begin
                            r_a <= w_ain[r][c];
                        end
                    end
                    assign w_ain[r][c+1] = r_a;
                end

                if (r < ROWS - 1) begin : g_pout
                    logic signed [PSUM_W-1:0] r_p;
                    // Partial sum passes down.
                    always_ff @(posedge clk) begin
                        if (reset) begin
                            r_p <= '0;
                        end else if (w_step) begin
                            r_p <= w_sum;
                        end
                    end
                    assign w_pin[r+1][c] = r_p;
                end else begin : g_yout
                    logic signed [OUT_W-1:0] r_y;
                    // Bottom row registers the converted column result.
                    always_ff @(posedge clk) begin
                        if (reset) begin
                            r_y <= '0;
                        end else if (w_step) begin
                            r_y <= to_out(w_sum);
                        end
                    end
                    assign w_ybot[c] = r_y;
                end
            end
        end

        for (genvar c = 0; c < COLS; c++) begin : g_dsk
            localparam int unsigned D = COLS - 1 - c;
            if (D == 0) begin : g_none
                assign y_data[c*OUT_W +: OUT_W] = w_ybot[c];
            end else begin : g_delay
                logic signed [OUT_W-1:0] r_dk [D];
                // Column c delayed so all columns of a vector leave together.
                always_ff @(posedge clk) begin
                    if (reset) begin
                        for (int k = 0; k < D; k++) begin
                            r_dk[k] <= '0;
                        end
                    end else if (w_step) begin
                        r_dk[0] <= w_ybot[c];
                        for (int k = 1; k < D; k++) begin
                            r_dk[k] <= r_dk[k-1];
                        end
                    end
                end
                assign y_data[c*OUT_W +: OUT_W] = r_dk[D-1];
            end
        end
    endgenerate

endmodule

// File: tb/tb_systolic_array_ws.sv
// Self-checking bench for systolic_array_ws: directed scenarios plus randomized
// traffic, scored against a dot-product model with a step-counting latency model.
module tb_systolic_array_ws;

    localparam int ROWS   = 3;
    localparam int COLS   = 3;
    localparam int DATA_W = 13;
    localparam int PSUM_W = 32;
    localparam int OUT_W  = 16;
    localparam int LAT    = ROWS + COLS - 1;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   w_valid;
    logic                   w_ready;
    logic [COLS*DATA_W-1:0] w_data;
    logic                   a_valid;
    logic                   a_ready;
    logic [ROWS*DATA_W-1:0] a_data;
    logic                   y_valid;
    logic                   y_ready;
    logic [COLS*OUT_W-1:0]  y_data;
    logic                   busy;

    systolic_array_ws #(
        .ROWS   (ROWS),
        .COLS   (COLS),
        .DATA_W (DATA_W),
        .PSUM_W (PSUM_W),
        .OUT_W  (OUT_W)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .w_valid (w_valid),
        .w_ready (w_ready),
        .w_data  (w_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_data  (y_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference state: weights as loaded, and expected results in flight.
    logic signed [DATA_W-1:0] m_w [ROWS][COLS];
    int                       m_wrow;
    logic [COLS*OUT_W-1:0]    q_y [$];
    int                       q_steps [$];
    logic                     mon_exp_v;
    logic [COLS*DATA_W-1:0]   wrows [ROWS];

    function automatic logic [COLS*OUT_W-1:0] model_y(input logic [ROWS*DATA_W-1:0] a);
        logic [COLS*OUT_W-1:0] y;
        longint                s;
        longint                ps;
        logic [PSUM_W-1:0]     p;
        y = '0;
        for (int c = 0; c < COLS; c++) begin
            s = 0;
            for (int r = 0; r < ROWS; r++) begin
                s = s + longint'($signed(a[r*DATA_W +: DATA_W])) * longint'(m_w[r][c]);
            end
            p  = s[PSUM_W-1:0];
            ps = longint'($signed(p));
`ifdef SYSTOLIC_SAT_EN
            if (ps > (longint'(1) << (OUT_W - 1)) - 1) ps = (longint'(1) << (OUT_W - 1)) - 1;
            if (ps < -(longint'(1) << (OUT_W - 1))) ps = -(longint'(1) << (OUT_W - 1));
`endif
            y[c*OUT_W +: OUT_W] = ps[OUT_W-1:0];
        end
        return y;
    endfunction

    function automatic logic [3*DATA_W-1:0] pack_d(input int x0, input int x1, input int x2);
        logic [3*DATA_W-1:0] v;
        v[0*DATA_W +: DATA_W] = DATA_W'(x0);
        v[1*DATA_W +: DATA_W] = DATA_W'(x1);
        v[2*DATA_W +: DATA_W] = DATA_W'(x2);
        return v;
    endfunction

    function automatic logic [3*OUT_W-1:0] pack_y(input int x0, input int x1, input int x2);
        logic [3*OUT_W-1:0] v;
        v[0*OUT_W +: OUT_W] = OUT_W'(x0);
        v[1*OUT_W +: OUT_W] = OUT_W'(x1);
        v[2*OUT_W +: OUT_W] = OUT_W'(x2);
        return v;
    endfunction

    function automatic logic [3*DATA_W-1:0] rand_vec();
        logic [3*DATA_W-1:0] v;
        for (int i = 0; i < 3; i++) v[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        return v;
    endfunction

    // Scoreboard: a vector is due once it has seen LAT stepping cycles.
    always @(negedge clk) begin
        if (reset) begin
            q_y.delete();
            q_steps.delete();
            m_wrow = 0;
            for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_w[r][c] = '0;
        end else begin
            mon_exp_v = (q_y.size() > 0) && (q_steps[0] == LAT);
            check_eq("y_valid", y_valid, mon_exp_v);
            if (y_valid && mon_exp_v) check_eq("y_data", y_data, q_y[0]);
            check_eq("busy", busy, q_y.size() != 0);
            if (w_valid && w_ready) begin
                for (int c = 0; c < COLS; c++) m_w[m_wrow][c] = w_data[c*DATA_W +: DATA_W];
                m_wrow = (m_wrow + 1) % ROWS;
            end
            if (a_valid && a_ready) begin
                q_y.push_back(model_y(a_data));
                q_steps.push_back(0);
            end
            if (y_valid && y_ready && mon_exp_v) begin
                void'(q_y.pop_front());
                void'(q_steps.pop_front());
                n_out++;
            end
            if (!y_valid || y_ready) begin
                foreach (q_steps[i]) if (q_steps[i] < LAT) q_steps[i] = q_steps[i] + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights();
        int n;
        for (int r = 0; r < ROWS; r++) begin
            w_valid = 1'b1;
            w_data  = wrows[r];
            n = 0;
            #1;
            while (!w_ready && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) check_eq("w_accept_timeout", w_ready, 1'b1);
            tick();
        end
        w_valid = 1'b0;
    endtask

    task automatic send_a(input logic [ROWS*DATA_W-1:0] d);
        int n;
        a_valid = 1'b1;
        a_data  = d;
        n = 0;
        #1;
        while (!a_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_eq("a_accept_timeout", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
    endtask

    task automatic wait_y(output logic [COLS*OUT_W-1:0] yd);
        int n;
        n = 0;
        while (!y_valid && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_eq("y_wait_timeout", y_valid, 1'b1);
        yd = y_data;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [COLS*OUT_W-1:0] yd;
        logic [4:0]            pat;
        int                    cyc;
        int                    base;
        int                    sent;
        int                    stall_cnt;

        w_valid = 1'b0;
        w_data  = '0;
        a_valid = 1'b0;
        a_data  = '0;
        y_ready = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_w_ready", w_ready, 1'b1);
        check_eq("rst_a_ready", a_ready, 1'b0);
        check_eq("rst_y_valid", y_valid, 1'b0);
        check_eq("rst_y_data", y_data, '0);
        check_eq("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick();

        // Identity weights, exact latency and back-to-back vectors.
        for (int r = 0; r < ROWS; r++) wrows[r] = pack_d(r == 0, r == 1, r == 2);
        load_weights();
        a_valid = 1'b1;
        a_data  = pack_d(1, 2, 3);
        #1;
        check_eq("a_ready_after_load", a_ready, 1'b1);
        tick();
        check_eq("id_y_valid_t1", y_valid, 1'b0);
        a_data = pack_d(-5, 0, 7);
        tick();
        a_valid = 1'b0;
        for (int k = 2; k < 5; k++) begin
            check_eq("id_y_valid_early", y_valid, 1'b0);
            tick();
        end
        check_eq("id_y_valid_t5", y_valid, 1'b1);
        check_eq("id_y_t5", y_data, pack_y(1, 2, 3));
        tick();
        check_eq("id_y_valid_t6", y_valid, 1'b1);
        check_eq("id_y_t6", y_data, pack_y(-5, 0, 7));
        tick();
        check_eq("id_y_valid_t7", y_valid, 1'b0);

        // Largest positive operands: saturate or wrap.
        for (int r = 0; r < ROWS; r++) wrows[r] = pack_d(4095, 4095, 4095);
        load_weights();
        send_a(pack_d(4095, 4095, 4095));
        wait_y(yd);
`ifdef SYSTOLIC_SAT_EN
        check_eq("sat_y", yd, pack_y(32767, 32767, 32767));
`else
        check_eq("wrap_y", yd, pack_y(-24573, -24573, -24573));
`endif

        // Six-vector stream with a three-cycle downstream stall.
        for (int r = 0; r < ROWS; r++) wrows[r] = rand_vec();
        load_weights();
        base = n_out;
        sent = 0;
        stall_cnt = 0;
        cyc = 0;
        while ((n_out - base) < 6 && cyc < 200) begin
            a_valid = (sent < 6);
            a_data  = rand_vec();
            y_ready = 1'b1;
            if (y_valid && stall_cnt < 3) begin
                y_ready = 1'b0;
                stall_cnt++;
            end
            #1;
            if (!y_ready) check_eq("a_ready_stall", a_ready, 1'b0);
            if (a_valid && a_ready) sent++;
            tick();
            cyc++;
        end
        a_valid = 1'b0;
        y_ready = 1'b1;
        check_eq("stream_count", n_out - base, 6);

        // Sparse input pattern reappears exactly LAT cycles later.
        pat = 5'b01101;
        for (int k = 0; k < 5; k++) begin
            a_valid = pat[k];
            a_data  = rand_vec();
            #1;
            check_eq("pat_a_ready", a_ready, 1'b1);
            tick();
        end
        a_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_eq("pat_y_valid", y_valid, pat[k]);
            tick();
        end

        // Reload request with two vectors in flight.
        a_valid = 1'b1;
        a_data  = rand_vec();
        tick();
        a_data = rand_vec();
        tick();
        for (int r = 0; r < ROWS; r++) wrows[r] = pack_d(1, 2, 3);
        w_valid = 1'b1;
        w_data  = wrows[0];
        #1;
        check_eq("a_ready_wprio", a_ready, 1'b0);
        check_eq("w_ready_drain", w_ready, 1'b0);
        cyc = 0;
        while (cyc < 50) begin
            if (w_ready) break;
            check_eq("a_ready_drain", a_ready, 1'b0);
            tick();
            cyc++;
        end
        check_eq("w_ready_rise_cycle", cyc, 6);
        a_valid = 1'b0;
        tick();
        check_eq("w_ready_beat1", w_ready, 1'b1);
        tick();
        check_eq("w_ready_beat2", w_ready, 1'b1);
        tick();
        w_valid = 1'b0;
        send_a(pack_d(1, 1, 1));
        wait_y(yd);
        check_eq("new_weights_y", yd, pack_y(3, 6, 9));

        // Reset with four vectors in flight.
        a_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_data = rand_vec();
            tick();
        end
        a_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_w_ready", w_ready, 1'b1);
        check_eq("mid_rst_a_ready", a_ready, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        for (int k = 0; k < 10; k++) begin
            check_eq("y_after_reset", y_valid, 1'b0);
            tick();
        end
        for (int r = 0; r < ROWS; r++) wrows[r] = '0;
        load_weights();
        send_a(pack_d(1, 1, 1));
        wait_y(yd);
        check_eq("zero_weights_y", yd, pack_y(0, 0, 0));

        // Randomized traffic with reloads under load.
        for (int round = 0; round < 3; round++) begin
            y_ready = 1'b1;
            for (int r = 0; r < ROWS; r++) wrows[r] = rand_vec();
            load_weights();
            for (int k = 0; k < 150; k++) begin
                a_valid = $urandom_range(0, 1) == 1;
                a_data  = rand_vec();
                y_ready = $urandom_range(0, 3) != 0;
                tick();
            end
            a_valid = 1'b0;
        end
        y_ready = 1'b1;
        cyc = 0;
        while (busy && cyc < 100) begin
            tick();
            cyc++;
        end
        check_eq("final_busy", busy, 1'b0);
        check_eq("leftover", q_y.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
